// File: rtl/sgd_axb_pkg.sv
// Shared types and constants for the SGD A/B line fetcher.
package sgd_axb_pkg;
    localparam int LINE_W            = 512;
    localparam int NUM_BITS_PER_BANK = 64;
    localparam int NUM_OF_BANKS      = 8;

    typedef enum logic {KIND_A, KIND_B} axb_kind_t;

    typedef enum logic [2:0] {
        IDLE, CMD_B, CMD_A, NEXT_GROUP, DRAIN, DONE
    } axb_state_t;
endpackage

// File: rtl/sgd_axb_kind_fifo.sv
// Queue of {kind, len} per issued read command; its head steers returning lines.
module sgd_axb_kind_fifo
    import sgd_axb_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       push_kind,
    input  logic [7:0] push_len,
    input  logic       pop,
    output logic       head_kind,
    output logic [7:0] head_len,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = $bits(axb_kind_t) + 8;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= {push_kind, push_len};

    assign {head_kind, head_len} = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/sgd_axb_fetch.sv
// Issues A/B burst reads for SGD jobs and routes returned lines into the
// per-engine A dispatch FIFOs and the shared B dispatch FIFO.
module sgd_axb_fetch
    import sgd_axb_pkg::*;
#(
    parameter int ENGINE_NUM      = 4,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [63:0]                  addr_a,
    input  logic [63:0]                  addr_b,
    input  logic [31:0]                  dimension,
    input  logic [31:0]                  number_of_samples,
    input  logic [31:0]                  number_of_bits,
    input  logic [31:0]                  number_of_epochs,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_cmd_valid,
    input  logic                         rd_cmd_ready,
    output logic [63:0]                  rd_cmd_addr,
    output logic [7:0]                   rd_cmd_len,
    input  logic [LINE_W-1:0]            rd_data,
    input  logic                         rd_data_valid,
    output logic                         rd_data_ready,
    output logic [ENGINE_NUM*LINE_W-1:0] dispatch_axb_a_data,
    output logic [ENGINE_NUM-1:0]        dispatch_axb_a_wr_en,
    input  logic [ENGINE_NUM-1:0]        dispatch_axb_a_almost_full,
    output logic [255:0]                 dispatch_axb_b_data,
    output logic                         dispatch_axb_b_wr_en,
    input  logic                         dispatch_axb_b_almost_full
);
    localparam int EW = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;

    axb_state_t  state;
    logic [31:0] cfg_bits, cfg_lines, cfg_pairs, cfg_epochs;
    logic [63:0] cfg_addr_a, cfg_addr_b, a_addr, b_addr;
    logic [31:0] pair_cnt, epoch_cnt, k_issued;
    logic        half;
    logic [15:0] outstanding;

    logic        kf_head_kind, kf_full, kf_empty, kf_pop;
    logic [7:0]  kf_head_len, head_cnt;
    logic [31:0] line_k, line_bit;
    logic [EW-1:0] eng;
    logic        b_hi;
    logic [255:0] b_upper;
    logic [LINE_W-1:0] a_line;

    logic        cmd_hs, data_hs;
    logic [31:0] a_rem;
    logic [7:0]  a_len;

    assign cmd_hs  = rd_cmd_valid && rd_cmd_ready;
    assign data_hs = rd_data_valid && rd_data_ready;
    assign a_rem   = cfg_lines - k_issued;
    assign a_len   = (a_rem > 32'(MAX_BURST)) ? 8'(MAX_BURST) : a_rem[7:0];

    function automatic logic credit_ok(input logic [15:0] outs, input logic [7:0] len);
        return (32'(outs) + 32'(len)) <= 32'(MAX_OUTSTANDING);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_cmd_valid <= 1'b0;
            rd_cmd_addr  <= '0;
            rd_cmd_len   <= '0;
            cfg_bits     <= '0;
            cfg_lines    <= '0;
            cfg_pairs    <= '0;
            cfg_epochs   <= '0;
            cfg_addr_a   <= '0;
            cfg_addr_b   <= '0;
            a_addr       <= '0;
            b_addr       <= '0;
            pair_cnt     <= '0;
            epoch_cnt    <= '0;
            k_issued     <= '0;
            half         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cfg_bits   <= number_of_bits;
                    cfg_lines  <= (dimension / NUM_BITS_PER_BANK) * number_of_bits;
                    cfg_pairs  <= number_of_samples >> 4;
                    cfg_epochs <= number_of_epochs;
                    cfg_addr_a <= addr_a;
                    cfg_addr_b <= addr_b;
                    a_addr     <= addr_a;
                    b_addr     <= addr_b;
                    pair_cnt   <= '0;
                    epoch_cnt  <= '0;
                    k_issued   <= '0;
                    half       <= 1'b0;
                    busy       <= 1'b1;
                    state      <= CMD_B;
                end
                CMD_B: begin
                    if (!rd_cmd_valid) begin
                        if (credit_ok(outstanding, 8'd1) && !kf_full) begin
                            rd_cmd_valid <= 1'b1;
                            rd_cmd_addr  <= b_addr;
                            rd_cmd_len   <= 8'd1;
                        end
                    end else if (rd_cmd_ready) begin
                        rd_cmd_valid <= 1'b0;
                        b_addr       <= b_addr + 64'd64;
                        state        <= CMD_A;
                    end
                end
                CMD_A: begin
                    if (!rd_cmd_valid) begin
                        if (credit_ok(outstanding, a_len) && !kf_full) begin
                            rd_cmd_valid <= 1'b1;
                            rd_cmd_addr  <= a_addr;
                            rd_cmd_len   <= a_len;
                        end
                    end else if (rd_cmd_ready) begin
                        rd_cmd_valid <= 1'b0;
                        a_addr       <= a_addr + (64'(rd_cmd_len) << 6);
                        if (k_issued + 32'(rd_cmd_len) >= cfg_lines) begin
                            k_issued <= '0;
                            state    <= NEXT_GROUP;
                        end else begin
                            k_issued <= k_issued + 32'(rd_cmd_len);
                        end
                    end
                end
                NEXT_GROUP: begin
                    if (!half) begin
                        half  <= 1'b1;
                        state <= CMD_A;
                    end else begin
                        half <= 1'b0;
                        if (pair_cnt == cfg_pairs - 1) begin
                            pair_cnt <= '0;
                            if (epoch_cnt == cfg_epochs - 1) begin
                                state <= DRAIN;
                            end else begin
                                // next epoch re-reads the same matrix and labels
                                epoch_cnt <= epoch_cnt + 1;
                                a_addr    <= cfg_addr_a;
                                b_addr    <= cfg_addr_b;
                                state     <= CMD_B;
                            end
                        end else begin
                            pair_cnt <= pair_cnt + 1;
                            state    <= CMD_B;
                        end
                    end
                end
                DRAIN: if (outstanding == '0 && kf_empty && !b_hi) begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) outstanding <= '0;
        else outstanding <= outstanding + (cmd_hs ? 16'(rd_cmd_len) : 16'd0) - 16'(data_hs);
    end

    sgd_axb_kind_fifo #(.DEPTH(MAX_OUTSTANDING)) u_kind_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_hs),
        .push_kind (state == CMD_B ? KIND_B : KIND_A),
        .push_len  (rd_cmd_len),
        .pop       (kf_pop),
        .head_kind (kf_head_kind),
        .head_len  (kf_head_len),
        .full      (kf_full),
        .empty     (kf_empty)
    );

    assign kf_pop = data_hs && (head_cnt == kf_head_len - 8'd1);

    always_comb begin
        rd_data_ready = 1'b0;
        if (!kf_empty && !b_hi)
            rd_data_ready = (kf_head_kind == KIND_B) ? !dispatch_axb_b_almost_full
                                                     : !dispatch_axb_a_almost_full[eng];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dispatch_axb_a_wr_en <= '0;
            dispatch_axb_b_wr_en <= 1'b0;
            dispatch_axb_b_data  <= '0;
            a_line               <= '0;
            b_upper              <= '0;
            b_hi                 <= 1'b0;
            head_cnt             <= '0;
            line_k               <= '0;
            line_bit             <= '0;
            eng                  <= '0;
        end else begin
            dispatch_axb_a_wr_en <= '0;
            dispatch_axb_b_wr_en <= 1'b0;
            if (b_hi) begin
                dispatch_axb_b_data  <= b_upper;
                dispatch_axb_b_wr_en <= 1'b1;
                b_hi                 <= 1'b0;
            end
            if (data_hs) begin
                head_cnt <= kf_pop ? 8'd0 : head_cnt + 8'd1;
                if (kf_head_kind == KIND_B) begin
                    dispatch_axb_b_data  <= rd_data[255:0];
                    dispatch_axb_b_wr_en <= 1'b1;
                    b_upper              <= rd_data[511:256];
                    b_hi                 <= 1'b1;
                end else begin
                    a_line                    <= rd_data;
                    dispatch_axb_a_wr_en[eng] <= 1'b1;
                    // engine advances every number_of_bits lines, restarts per group
                    if (line_k == cfg_lines - 1) begin
                        line_k   <= '0;
                        line_bit <= '0;
                        eng      <= '0;
                    end else begin
                        line_k <= line_k + 1;
                        if (line_bit == cfg_bits - 1) begin
                            line_bit <= '0;
                            eng      <= (eng == EW'(ENGINE_NUM - 1)) ? '0 : eng + EW'(1);
                        end else begin
                            line_bit <= line_bit + 1;
                        end
                    end
                end
            end
        end
    end

    assign dispatch_axb_a_data = {ENGINE_NUM{a_line}};
endmodule

// File: tb/tb_sgd_axb_fetch.sv
// Scoreboard bench: a job-level model predicts commands and dispatch writes.
module tb_sgd_axb_fetch;
    localparam int EN = 4, MB = 16, MO = 64;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [63:0] addr_a = '0, addr_b = '0;
    logic [31:0] dimension = '0, number_of_samples = '0, number_of_bits = '0, number_of_epochs = '0;
    logic busy, done, rd_cmd_valid, rd_data_ready, b_wr;
    logic rd_cmd_ready = 1'b0, rd_data_valid = 1'b0, af_b = 1'b0;
    logic [63:0] rd_cmd_addr;
    logic [7:0] rd_cmd_len;
    logic [511:0] rd_data = '0;
    logic [EN*512-1:0] a_data;
    logic [EN-1:0] a_wr, af_a = '0;
    logic [255:0] b_data;

    always #5 clk = ~clk;

    sgd_axb_fetch #(.ENGINE_NUM(EN), .MAX_BURST(MB), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_a(addr_a), .addr_b(addr_b),
        .dimension(dimension), .number_of_samples(number_of_samples),
        .number_of_bits(number_of_bits), .number_of_epochs(number_of_epochs),
        .busy(busy), .done(done), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .dispatch_axb_a_data(a_data), .dispatch_axb_a_wr_en(a_wr),
        .dispatch_axb_a_almost_full(af_a), .dispatch_axb_b_data(b_data),
        .dispatch_axb_b_wr_en(b_wr), .dispatch_axb_b_almost_full(af_b)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } cmd_t;
    typedef struct { int tgt; logic [511:0] data; } wr_t;
    cmd_t exp_cmd[$];
    wr_t  exp_wr[$];
    logic [63:0] ret_q[$];

    int total = 0, bad = 0, cyc = 0, done_cnt = 0, last_wr_cyc = -100, issued = 0;
    int p_rdy = 100, p_val = 100, e2_hold = 0;
    bit af_rand = 0, val_hold = 0, hold_v = 0;
    logic [63:0] hold_a;
    logic [7:0] hold_l;
    int over[EN+1];

    function automatic logic [511:0] line_of(input logic [63:0] a);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = (a * 64'(i + 3)) ^ {32'hC0DE0000 + 32'(i), a[31:0]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Job model: command list and global write order from the address/routing rules.
    task automatic build(input logic [63:0] aa, input logic [63:0] ab, input int dim, input int ns,
                         input int nb, input int ne);
        int L, g;
        logic [511:0] lb;
        L = dim / 64 * nb;
        for (int e = 0; e < ne; e++)
            for (int j = 0; j < ns / 16; j++) begin
                lb = line_of(ab + 64'(j) * 64);
                exp_cmd.push_back('{ab + 64'(j) * 64, 8'd1});
                exp_wr.push_back('{EN, {256'b0, lb[255:0]}});
                exp_wr.push_back('{EN, {256'b0, lb[511:256]}});
                for (int h = 0; h < 2; h++) begin
                    g = 2 * j + h;
                    for (int k = 0; k < L; k += MB)
                        exp_cmd.push_back('{aa + 64'(g * L + k) * 64, 8'((L - k < MB) ? L - k : MB)});
                    for (int k = 0; k < L; k++)
                        exp_wr.push_back('{(k / nb) % EN, line_of(aa + 64'(g * L + k) * 64)});
                end
            end
    endtask

    task automatic wr_mon();
        int nw, t;
        logic [511:0] d;
        wr_t e;
        nw = $countones(a_wr) + int'(b_wr);
        t = -1;
        d = '0;
        for (int i = 0; i < EN; i++) if (a_wr[i]) begin t = i; d = a_data[i*512 +: 512]; end
        if (b_wr) begin t = EN; d = {256'b0, b_data}; end
        for (int i = 0; i <= EN; i++) begin
            logic f;
            f = (i == EN) ? af_b : af_a[i];
            if (!f) over[i] = 0;
            else if (t == i) begin
                over[i]++;
                chk("af_absorb", 512'(over[i] <= 2), 512'(1));
            end
        end
        if (nw == 0) return;
        last_wr_cyc = cyc;
        if (nw > 1) chk("single_write", 512'(nw), 512'(1));
        if (exp_wr.size() == 0) chk("unexpected_write", 512'(t), 512'(-1));
        else begin
            e = exp_wr.pop_front();
            chk("wr_target", 512'(t), 512'(e.tgt));
            chk("wr_data", d, e.data);
        end
    endtask

    // Memory/downstream model: drives inputs at negedge, resolves handshakes at negedge+1.
    initial forever begin
        @(negedge clk);
        cyc++;
        wr_mon();
        if (done) begin
            done_cnt++;
            chk("done_latency", 512'(cyc - last_wr_cyc), 512'(1));
        end
        rd_cmd_ready = ($urandom_range(99) < p_rdy);
        af_a = '0;
        af_b = 1'b0;
        if (af_rand) begin
            for (int i = 0; i < EN; i++) af_a[i] = ($urandom_range(7) == 0);
            af_b = ($urandom_range(7) == 0);
        end
        if (e2_hold > 0) begin af_a[2] = 1'b1; e2_hold--; end
        if (ret_q.size() > 0 && !val_hold && $urandom_range(99) < p_val) begin
            rd_data_valid = 1'b1;
            rd_data = line_of(ret_q[0]);
        end else begin
            rd_data_valid = 1'b0;
            rd_data = '0;
        end
        #1;
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("cmd_hold_valid", 512'(rd_cmd_valid), 512'(1));
                chk("cmd_hold_addr", 512'(rd_cmd_addr), 512'(hold_a));
                chk("cmd_hold_len", 512'(rd_cmd_len), 512'(hold_l));
            end
            hold_v = rd_cmd_valid && !rd_cmd_ready;
            hold_a = rd_cmd_addr;
            hold_l = rd_cmd_len;
            if (rd_cmd_valid && rd_cmd_ready) begin
                if (exp_cmd.size() == 0) chk("unexpected_cmd", 512'(rd_cmd_addr), 512'(0));
                else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    chk("cmd_addr", 512'(rd_cmd_addr), 512'(c.addr));
                    chk("cmd_len", 512'(rd_cmd_len), 512'(c.len));
                end
                for (int i = 0; i < int'(rd_cmd_len); i++) ret_q.push_back(rd_cmd_addr + 64'(i) * 64);
                issued += int'(rd_cmd_len);
            end
            if (rd_data_valid && rd_data_ready && ret_q.size() > 0) void'(ret_q.pop_front());
        end
    end

    task automatic start_job(input logic [63:0] aa, input logic [63:0] ab, input int dim,
                             input int ns, input int nb, input int ne);
        build(aa, ab, dim, ns, nb, ne);
        @(negedge clk);
        addr_a = aa; addr_b = ab; dimension = dim; number_of_samples = ns;
        number_of_bits = nb; number_of_epochs = ne;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 512'(busy), 512'(1));
    endtask

    task automatic finish_job(input int d0);
        for (int i = 0; i < 30000 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) chk("done_timeout", 512'(0), 512'(1));
        repeat (20) @(negedge clk);
        chk("done_count", 512'(done_cnt - d0), 512'(1));
        chk("cmds_left", 512'(exp_cmd.size()), 512'(0));
        chk("writes_left", 512'(exp_wr.size()), 512'(0));
        chk("busy_idle", 512'(busy), 512'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cmd_valid"}, 512'(rd_cmd_valid), 512'(0));
        chk({tag, "_data_ready"}, 512'(rd_data_ready), 512'(0));
        chk({tag, "_busy_done"}, 512'({busy, done}), 512'(0));
        chk({tag, "_wr_en"}, 512'({a_wr, b_wr}), 512'(0));
        chk({tag, "_a_data"}, a_data[511:0], 512'(0));
        chk({tag, "_b_data"}, 512'(b_data), 512'(0));
    endtask

    initial begin
        int d0;
        logic [63:0] ra, rb;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // basic job, always ready
        d0 = done_cnt;
        start_job(64'h1000_0000, 64'h2000_0000, 256, 16, 8, 1);
        finish_job(d0);

        // engine 2 almost_full for 100 cycles
        p_rdy = 70; p_val = 80;
        d0 = done_cnt;
        start_job(64'h3000_0000, 64'h4000_0040, 512, 16, 4, 1);
        e2_hold = 100;
        finish_job(d0);

        // no returned data: issue must stop at the outstanding limit
        p_rdy = 100; p_val = 100; val_hold = 1;
        issued = 0;
        d0 = done_cnt;
        start_job(64'h5000_0000, 64'h6000_0000, 256, 1024, 8, 1);
        repeat (300) @(negedge clk);
        chk("stall_limit", 512'(issued <= MO), 512'(1));
        chk("stall_next_blocked", 512'(exp_cmd.size() > 0 && issued + int'(exp_cmd[0].len) > MO), 512'(1));
        val_hold = 0;
        finish_job(d0);

        // three epochs, single done
        d0 = done_cnt;
        start_job(64'h7000_0000, 64'h8000_0000, 256, 32, 8, 3);
        finish_job(d0);

        // reset mid-burst, then the basic job again
        start_job(64'h1000_0000, 64'h2000_0000, 256, 16, 8, 1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        exp_cmd.delete(); exp_wr.delete(); ret_q.delete();
        rst_n = 1'b1;
        d0 = done_cnt;
        start_job(64'h1000_0000, 64'h2000_0000, 256, 16, 8, 1);
        finish_job(d0);

        // random jobs with backpressure; a start pulse while busy must be ignored
        af_rand = 1;
        for (int r = 0; r < 3; r++) begin
            p_rdy = $urandom_range(100, 40);
            p_val = $urandom_range(100, 40);
            ra = {32'($urandom_range(15)), $urandom} & ~64'h3F;
            rb = {32'($urandom_range(15)) + 32'h10, $urandom} & ~64'h3F;
            d0 = done_cnt;
            start_job(ra, rb, 256 * $urandom_range(2, 1), 16 * $urandom_range(3, 1),
                      $urandom_range(12, 1), $urandom_range(2, 1));
            repeat (30) @(negedge clk);
            addr_a = 64'hDEAD_0000; dimension = 1024; number_of_bits = 3;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            finish_job(d0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
